debounce_pulse: RTL
===================

DEBOUNCE_PULSE -- requirements
Module: debounce_pulse

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, number of consecutive identical synchronized samples required to accept a level change; legal range 2..65535.
REQ-002 Parameter CNT_W, default $clog2(STABLE_CYCLES)+1, width of the internal stability counter.
REQ-003 Port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port btn_i  input  1  raw, asynchronous, possibly bouncing button level.
REQ-006 Port db_o  output  1  debounced level, registered.
REQ-007 Port press_o  output  1  one-cycle pulse on accepted 0->1 transition, registered; intended to drive a counter's incr input.
REQ-008 Port release_o  output  1  one-cycle pulse on accepted 1->0 transition, registered.

Function
REQ-009 btn_i SHALL pass through a two-flop synchronizer; its output s is the only form of btn_i used by the remaining logic.
REQ-010 The FSM SHALL have four states: LOW, WAIT_HIGH, HIGH, WAIT_LOW.
REQ-011 LOW: s=1 -> WAIT_HIGH with cnt=1; otherwise stay.
REQ-012 WAIT_HIGH: s=0 -> LOW with cnt=0 (bounce abort); s=1 and cnt==STABLE_CYCLES-1 -> HIGH with cnt=0; otherwise cnt+1.
REQ-013 HIGH: s=0 -> WAIT_LOW with cnt=1; otherwise stay.
REQ-014 WAIT_LOW: s=1 -> HIGH with cnt=0 (bounce abort); s=0 and cnt==STABLE_CYCLES-1 -> LOW with cnt=0; otherwise cnt+1.
REQ-015 db_o SHALL be 1 exactly when the state is HIGH or WAIT_LOW.
REQ-016 press_o SHALL be 1 for exactly the one cycle following the edge that enters HIGH from WAIT_HIGH; entry into HIGH from WAIT_LOW SHALL NOT pulse.
REQ-017 release_o SHALL be 1 for exactly the one cycle following the edge that enters LOW from WAIT_LOW; entry into LOW from WAIT_HIGH SHALL NOT pulse.
REQ-018 Latency: if btn_i is stable at 1 from before edge k, press_o SHALL be asserted after edge k+1+STABLE_CYCLES and deasserted after edge k+2+STABLE_CYCLES.
REQ-019 press_o and release_o SHALL never be asserted in the same cycle; two pulses SHALL be separated by at least STABLE_CYCLES cycles.
REQ-020 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.

Reset
REQ-021 With rst=1 at a rising edge: both synchronizer flops=0, state=LOW, cnt=0, db_o=0, press_o=0, release_o=0.
REQ-022 Reset SHALL take priority over every transition, including mid-WAIT and during a pulse cycle; a pulse in flight is dropped.
REQ-023 If btn_i is held at 1 across reset deassertion, the block SHALL treat it as a new press and emit one press_o after the REQ-018 latency.

Structure
REQ-024 Package debounce_pkg SHALL hold the four-state enum type and the default STABLE_CYCLES constant.
REQ-025 The two-flop synchronizer SHALL be a separate sub-module sync_2ff (clk, rst, d, q), reset to 0.
REQ-026 The FSM, counter and output registers SHALL live in debounce_pulse; no other sub-modules.

Verification (STABLE_CYCLES=4, CLK_PERIOD=10 ns)
REQ-027 Clean press: rst 2 cycles, btn_i 0->1 held 20 cycles -> press_o high for exactly 1 cycle, 6 edges after the first edge sampling btn_i=1; db_o=1 thereafter; release_o stays 0.
REQ-028 Bounce: btn_i toggles 1,0,1,0 on successive cycles, then holds 1 -> exactly one press_o, timed from the final 0->1; no pulse during the bouncing.
REQ-029 Short glitch: btn_i=1 for 3 cycles, then 0 -> no press_o, db_o stays 0; FSM returns to LOW.
REQ-030 Release: from HIGH, btn_i=0 held 10 cycles -> exactly one release_o, 6 edges after first sample of 0; db_o=0.
REQ-031 Reset mid-operation: rst pulsed 1 cycle while in WAIT_HIGH with cnt=2 -> all outputs 0 next cycle; btn_i still 1 -> one press_o 6 edges after reset release.
REQ-032 Integration: press_o drives incr of the 8-bit counter (rst low); 3 clean presses with bounce -> count_reg=3, never 4 or more.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the button debouncer: state encoding,
// default stability window and a helper mapping a state to its debounced level.
package debounce_pkg;

    localparam int unsigned STABLE_CYCLES_DEFAULT = 32'd4;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } db_state_e;

    // The debounced level stays high while a release is still being qualified.
    function automatic logic state_is_high(input db_state_e st);
        logic lvl;
        case (st)
            ST_HIGH:     lvl = 1'b1;
            ST_WAIT_LOW: lvl = 1'b1;
            default:     lvl = 1'b0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    // Two-stage capture chain, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/debounce_pulse.sv
// Button debouncer: a level change is accepted only after STABLE_CYCLES identical
// synchronized samples; accepted rising/falling changes emit one-cycle pulses.
module debounce_pulse
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic db_o,
    output logic press_o,
    output logic release_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 32'd1);

    logic             sync_s;
    db_state_e        state_q;
    db_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             db_q;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_i),
        .q   (sync_s)
    );

    // Next-state logic; a sample that disagrees during a wait aborts the change.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (sync_s) begin
                    state_d = ST_WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = ST_LOW;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_WAIT_HIGH: begin
                if (!sync_s) begin
                    state_d = ST_LOW;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = CNT_ZERO;
                    press_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_HIGH;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!sync_s) begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = ST_HIGH;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_WAIT_LOW: begin
                if (sync_s) begin
                    state_d = ST_HIGH;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_LOW;
                    cnt_d     = CNT_ZERO;
                    release_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered outputs; reset drops any pulse in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_LOW;
            cnt_q     <= CNT_ZERO;
            db_q      <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            db_q      <= state_is_high(state_d);
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign db_o      = db_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule
